gen_mtx_burst: RTL and testbench
================================

Name: gen_mtx_burst

Overview:
- Programmable rectangular-pulse source; it is the transmit-side counterpart of the MTX period/frequency measurer.
- Produces a test signal MTX with period P and high time H, both counted in ce ticks (normally ce01us).
- Runs continuously or emits a burst of N periods.
- Output is routed to the measurer's MTX input and to a JB/JC pin.
- Lets the team self-check the meter against known periods without external equipment.

Parameters:
- W, 16, width of the period, high-time and phase counters (ticks).
- NW, 10, width of the burst length and period-count registers.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  tick enable, one clk wide; all timing is counted in ce ticks.
- start  in  1  one-clk start strobe.
- stop  in  1  one-clk stop request.
- P  in  W  period in ticks; live input.
- H  in  W  high time in ticks; live input.
- N  in  NW  burst length in periods; 0 means continuous.
- MTX  out  1  generated waveform, registered.
- frontMTX  out  1  one-clk pulse in the cycle MTX first reads 1 after a 0.
- busy  out  1  high while in RUN.
- done  out  1  one-clk pulse when a burst or a stop completes.
- cnt  out  NW  number of completed periods since the last start; wraps.

Behaviour:
- Reset (async, rst_n=0) forces:
  - outputs: MTX=0, frontMTX=0, busy=0, done=0, cnt=0;
  - internal state: IDLE, phase ph=0, shadow registers Ps=2 and Hs=0, stop-pending flag cleared.
- States: IDLE and RUN.
- IDLE → RUN:
  - Taken on the clk edge where start=1 and stop=0; ce is not required.
  - On that edge: Ps=max(P,2), Hs=H, Ns=N, ph=0, cnt=0, MTX=(Hs>0).
  - The output is valid on the first cycle after the start edge, so latency is 1 clk.
- IDLE with start=1 and stop=1 on the same edge: stop wins; the block stays in IDLE and does not pulse done.
- RUN, edges with ce=0: everything holds.
- RUN, edges with ce=1:
  - If ph<Ps-1: ph=ph+1 and MTX=(ph+1 < Hs).
  - If ph=Ps-1, a period boundary:
    - ph=0 and cnt=cnt+1, modulo 2^NW;
    - Ps and Hs reload from the live P and H, with P<2 coerced to 2;
    - MTX=(new Hs>0).
    - P and H are therefore never applied mid-period, so live switch changes cannot glitch the output.
- Output duty rules:
  - Hs=0: MTX stays 0.
  - Hs≥Ps: MTX stays 1 for the whole period, and frontMTX does not pulse at the boundary.
- Ending a burst or a stop:
  - Trigger: a boundary where either (Ns≠0 and the new cnt equals Ns) or the stop-pending flag is set.
  - On that edge: RUN→IDLE, MTX=0, done=1 for one clk.
  - cnt keeps its final value.
- stop in RUN sets stop-pending; the current period still finishes, so stopping is graceful.
- start in RUN is ignored.
- frontMTX is registered as MTX_next & ~MTX, so it is aligned with the first high cycle of MTX.
- busy=1 exactly while the state is RUN.
- rst_n asserted mid-period: the block aborts immediately to the reset values, with no done pulse.

Optional Feature:
- Macro: GEN_MTX_SWEEP_EN.
- Defined:
  - adds input STEP, W bits;
  - at each period boundary, Ps reloads as min(Ps+STEP, 2^W-1) instead of P, so the period sweeps upward;
  - the first period after start still uses P;
  - Hs is still taken from H.
- Undefined: the STEP port does not exist and Ps always reloads from P.

Test Plan:
- Continuous run, ce every clk:
  - Stimulus: P=10, H=3, N=0, start.
  - Required: MTX high 3 clks and low 7 clks repeatedly; frontMTX pulses every 10 clks; cnt=1,2,3… at each boundary; busy=1.
- Burst:
  - Stimulus: P=4, H=2, N=3, ce every 2nd clk.
  - Required: exactly 3 periods of 8 clks each; done pulses once in the same cycle MTX returns to 0; cnt=3; busy=0.
- Graceful stop and stop priority:
  - Stimulus: stop at ph=5 while P=10.
  - Required: the period completes, then IDLE and done=1.
  - Stimulus: start and stop on the same edge while IDLE.
  - Required: the block stays in IDLE and done=0.
- Edge coercion:
  - Stimulus: P=0, H=1.
  - Required: period is 2 ticks, 1 high.
  - Stimulus: H=0.
  - Required: MTX=0 throughout, no frontMTX.
  - Stimulus: H=12, P=10.
  - Required: MTX=1 constantly and frontMTX only once, after start.
- Live change plus reset:
  - Stimulus: change P from 10 to 6 mid-period.
  - Required: the current period stays 10 ticks and the next is 6.
  - Stimulus: assert rst_n=0 mid-high.
  - Required: MTX=0, cnt=0, busy=0 immediately, with no done pulse.
- Sweep, only with GEN_MTX_SWEEP_EN defined:
  - Stimulus: P=4, STEP=2.
  - Required: successive periods of 4, 6, 8, 10 ticks.

Source files
------------

// File: rtl/gen_mtx_burst.sv
// Programmable rectangular-pulse source: MTX with period Ps and high time Hs counted in ce ticks, continuous or N-period burst.
// Latency: MTX valid 1 clk after the start edge; frontMTX/done are registered one-clk pulses aligned with MTX.
// Backpressure: none; start is ignored while running, stop is deferred to the end of the current period.
//
// Ports: clk, rst_n (async active-low), ce (tick enable), start/stop strobes,
//        P/H (live period/high time, sampled only at period boundaries), N (burst length, 0 = continuous),
//        MTX, frontMTX, busy, done, cnt (completed periods since last start, wraps).
// Optional: define GEN_MTX_SWEEP_EN to add input STEP; each boundary then reloads Ps as min(Ps+STEP, 2^W-1).
module gen_mtx_burst #(
    parameter int W  = 16,
    parameter int NW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  P,
    input  logic [W-1:0]  H,
    input  logic [NW-1:0] N,
`ifdef GEN_MTX_SWEEP_EN
    input  logic [W-1:0]  STEP,
`endif
    output logic          MTX,
    output logic          frontMTX,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] cnt
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  ph_q, ph_d;
    logic [W-1:0]  ps_q, ps_d;
    logic [W-1:0]  hs_q, hs_d;
    logic [NW-1:0] ns_q, ns_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          mtx_q, mtx_d;
    logic          front_q, front_d;
    logic          done_q, done_d;
    logic          stp_q, stp_d;

    // A period shorter than 2 ticks cannot show both levels, so it is coerced up.
    logic [W-1:0]  p_min2;
    logic [W-1:0]  ps_reload;
    assign p_min2 = (P < W'(2)) ? W'(2) : P;

`ifdef GEN_MTX_SWEEP_EN
    // Saturating sweep: the carry bit means the sum passed 2^W-1.
    logic [W:0] sweep_sum;
    assign sweep_sum = {1'b0, ps_q} + {1'b0, STEP};
    assign ps_reload = sweep_sum[W] ? {W{1'b1}} : sweep_sum[W-1:0];
`else
    assign ps_reload = p_min2;
`endif

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        ps_d    = ps_q;
        hs_d    = hs_q;
        ns_d    = ns_q;
        cnt_d   = cnt_q;
        mtx_d   = mtx_q;
        stp_d   = stp_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // stop on the same edge as start wins: stay idle, no done.
                if (start && !stop) begin
                    state_d = S_RUN;
                    ps_d    = p_min2;
                    hs_d    = H;
                    ns_d    = N;
                    ph_d    = '0;
                    cnt_d   = '0;
                    stp_d   = 1'b0;
                    mtx_d   = (H != '0);
                end
            end
            default: begin
                if (stop) stp_d = 1'b1;
                if (ce) begin
                    if (ph_q != ps_q - W'(1)) begin
                        ph_d  = ph_q + W'(1);
                        mtx_d = (ph_q + W'(1) < hs_q);
                    end else begin
                        // Period boundary: the only place shadows reload, so live P/H never glitch MTX.
                        ph_d  = '0;
                        cnt_d = cnt_q + NW'(1);
                        if (((ns_q != '0) && (cnt_d == ns_q)) || stp_q) begin
                            state_d = S_IDLE;
                            mtx_d   = 1'b0;
                            done_d  = 1'b1;
                            stp_d   = 1'b0;
                        end else begin
                            ps_d  = ps_reload;
                            hs_d  = H;
                            mtx_d = (H != '0);
                        end
                    end
                end
            end
        endcase
        front_d = mtx_d & ~mtx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            ps_q    <= W'(2);
            hs_q    <= '0;
            ns_q    <= '0;
            cnt_q   <= '0;
            mtx_q   <= 1'b0;
            front_q <= 1'b0;
            done_q  <= 1'b0;
            stp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            ps_q    <= ps_d;
            hs_q    <= hs_d;
            ns_q    <= ns_d;
            cnt_q   <= cnt_d;
            mtx_q   <= mtx_d;
            front_q <= front_d;
            done_q  <= done_d;
            stp_q   <= stp_d;
        end
    end

    assign MTX      = mtx_q;
    assign frontMTX = front_q;
    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign cnt      = cnt_q;

endmodule

// File: tb/tb_gen_mtx_burst.sv
// Bench for gen_mtx_burst: expected waveforms are built as a flat per-tick level list from the
// period/high-time rules, then walked one clk at a time as ce ticks arrive.
// Each scenario resets the block first so they are independent.
module tb_gen_mtx_burst;
    localparam int W  = 16;
    localparam int NW = 10;

    logic          clk;
    logic          rst_n;
    logic          ce;
    logic          start;
    logic          stop;
    logic [W-1:0]  P;
    logic [W-1:0]  H;
    logic [NW-1:0] N;
`ifdef GEN_MTX_SWEEP_EN
    logic [W-1:0]  STEP;
`endif
    logic          MTX;
    logic          frontMTX;
    logic          busy;
    logic          done;
    logic [NW-1:0] cnt;

    int total;
    int bad;
    int plist[$];
    int hlist[$];

    gen_mtx_burst #(.W(W), .NW(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .start    (start),
        .stop     (stop),
        .P        (P),
        .H        (H),
        .N        (N),
`ifdef GEN_MTX_SWEEP_EN
        .STEP     (STEP),
`endif
        .MTX      (MTX),
        .frontMTX (frontMTX),
        .busy     (busy),
        .done     (done),
        .cnt      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        ce    = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    task automatic fill(input int p, input int h, input int nper);
        plist.delete();
        hlist.delete();
        for (int k = 0; k < nper; k++) begin
            plist.push_back(p);
            hlist.push_back(h);
        end
    endtask

    // ce_mode: 0 = every clk, 1 = every 2nd clk, 2 = random (about 2 in 3).
    task automatic run_wave(input string nm, input logic [W-1:0] p0, input logic [W-1:0] h0,
                            input logic [NW-1:0] n0, input int nclk, input int ce_mode,
                            input int stop_clk, input int chg_clk, input logic [W-1:0] chg_p);
        bit lvl[$];
        bit bnd[$];
        int idx;
        bit run;
        int cnt_m;
        bit prev;
        bit mtx_m;
        bit front_m;
        bit done_m;
        bit ce_now;
        logic [NW+3:0] exp_v;
        logic [NW+3:0] got_v;
        foreach (plist[k]) begin
            for (int j = 0; j < plist[k]; j++) begin
                lvl.push_back(j < hlist[k]);
                bnd.push_back(j == plist[k] - 1);
            end
        end
        do_reset();
        P = p0; H = h0; N = n0;
        idx = 0; run = 0; cnt_m = 0; prev = 0;
        for (int c = 0; c < nclk; c++) begin
            if (c == 0) begin
                start  = 1'b1;
                ce_now = 1'b0;
            end else begin
                start = 1'b0;
                case (ce_mode)
                    0:       ce_now = 1'b1;
                    1:       ce_now = (c % 2) == 1;
                    default: ce_now = ($urandom_range(0, 2) != 0);
                endcase
            end
            ce   = ce_now;
            stop = (c == stop_clk);
            if (c == chg_clk) P = chg_p;
            @(posedge clk);
            done_m = 0;
            if (c == 0) begin
                run = 1;
            end else if (run && ce_now) begin
                if (bnd[idx]) cnt_m++;
                idx++;
                if (idx == lvl.size()) begin
                    run    = 0;
                    done_m = 1;
                end
            end
            mtx_m   = run ? lvl[idx] : 1'b0;
            front_m = mtx_m & ~prev;
            prev    = mtx_m;
            exp_v   = {mtx_m, front_m, run, done_m, NW'(cnt_m)};
            #1 got_v = {MTX, frontMTX, busy, done, cnt};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL %s cyc=%0d mtx/front/busy/done/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         nm, c, got_v[NW+3], got_v[NW+2], got_v[NW+1], got_v[NW], got_v[NW-1:0],
                         exp_v[NW+3], exp_v[NW+2], exp_v[NW+1], exp_v[NW], exp_v[NW-1:0]);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        ce    = 1'b0;
    endtask

    task automatic test_reset();
        logic [NW+3:0] got_v;
        // H >= P keeps MTX high, so a reset has something visible to clear.
        fill(5, 5, 10);
        run_wave("reset_pre", 16'd5, 16'd5, 10'd0, 8, 0, -1, -1, 16'd0);
        #2 rst_n = 1'b0;
        #1 got_v = {MTX, frontMTX, busy, done, cnt};
        total++;
        if (got_v !== '0) begin
            bad++;
            $display("FAIL reset_values got %b want 0", got_v);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        fill(10, 3, 8);
        run_wave("continuous", 16'd10, 16'd3, 10'd0, 45, 0, -1, -1, 16'd0);
    endtask

    task automatic test_burst();
        fill(4, 2, 3);
        run_wave("burst", 16'd4, 16'd2, 10'd3, 34, 1, -1, -1, 16'd0);
        total++;
        if (cnt !== 10'd3 || busy !== 1'b0) begin
            bad++;
            $display("FAIL burst_final cnt=%0d busy=%b want cnt=3 busy=0", cnt, busy);
        end
    endtask

    task automatic test_stop();
        // Stop sampled at ph=6 edge; the first period still completes.
        fill(10, 3, 1);
        run_wave("graceful_stop", 16'd10, 16'd3, 10'd0, 20, 0, 6, -1, 16'd0);
    endtask

    task automatic test_stop_priority();
        logic [NW+3:0] got_v;
        do_reset();
        P = 16'd10; H = 16'd3; N = 10'd0;
        start = 1'b1; stop = 1'b1; ce = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            got_v = {MTX, frontMTX, busy, done, cnt};
            total++;
            if (got_v !== '0) begin
                bad++;
                $display("FAIL stop_priority cyc=%0d got %b want 0", c, got_v);
            end
            @(posedge clk);
            #1;
        end
        ce = 1'b0;
    endtask

    task automatic test_coerce();
        fill(2, 1, 12);
        run_wave("coerce_p0", 16'd0, 16'd1, 10'd0, 20, 0, -1, -1, 16'd0);
        fill(10, 0, 4);
        run_wave("h_zero", 16'd10, 16'd0, 10'd0, 25, 0, -1, -1, 16'd0);
        fill(10, 12, 4);
        run_wave("h_over_p", 16'd10, 16'd12, 10'd0, 25, 0, -1, -1, 16'd0);
    endtask

    task automatic test_live_change();
        fill(6, 3, 6);
        plist[0] = 10;
        run_wave("live_p", 16'd10, 16'd3, 10'd0, 30, 0, -1, 4, 16'd6);
    endtask

    task automatic test_reset_mid();
        logic [NW+3:0] got_v;
        fill(10, 3, 4);
        // Last sampled cycle is tick 21: period 2, second high tick, cnt=2.
        run_wave("pre_reset", 16'd10, 16'd3, 10'd0, 22, 0, -1, -1, 16'd0);
        #2 rst_n = 1'b0;
        #1 got_v = {MTX, frontMTX, busy, done, cnt};
        total++;
        if (got_v !== '0) begin
            bad++;
            $display("FAIL reset_mid got %b want 0", got_v);
        end
        @(posedge clk);
        #1 total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_hold done=%b busy=%b want 0/0", done, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int p, h, n, pe, tks;
            p  = $urandom_range(0, 7);
            h  = $urandom_range(0, 9);
            n  = $urandom_range(1, 4);
            pe = (p < 2) ? 2 : p;
            fill(pe, h, n);
            tks = pe * n;
            run_wave($sformatf("random%0d", it), W'(p), W'(h), NW'(n), 3 * tks + 12, 2, -1, -1, 16'd0);
        end
    endtask

`ifdef GEN_MTX_SWEEP_EN
    task automatic test_sweep();
        plist.delete();
        hlist.delete();
        for (int k = 0; k < 6; k++) begin
            plist.push_back(4 + 2 * k);
            hlist.push_back(1);
        end
        STEP = 16'd2;
        run_wave("sweep", 16'd4, 16'd1, 10'd0, 40, 0, -1, -1, 16'd0);
        STEP = 16'd0;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ce    = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        P     = '0;
        H     = '0;
        N     = '0;
`ifdef GEN_MTX_SWEEP_EN
        STEP  = '0;
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        test_reset();
        test_continuous();
        test_burst();
        test_stop();
        test_stop_priority();
        test_coerce();
        test_live_change();
        test_reset_mid();
        test_random();
`ifdef GEN_MTX_SWEEP_EN
        test_sweep();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
